// File: rtl/bus_arbiter_pkg.sv
// Shared types for the bus arbiter slice.
//   ttype_e     : bus transaction direction (READ / WRITE)
//   tsize_e     : bus transfer size
//   arb_state_e : arbiter FSM states (IDLE / BUSY)
//   idx_width() : width of a master index, never less than one bit
package bus_arbiter_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } tsize_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin winner selection, purely combinational.
// Ports:
//   i_req   [N_MASTERS-1:0] : request vector
//   i_last  [IW-1:0]        : most recently granted index (lowest priority)
//   o_valid                 : at least one request present
//   o_idx   [IW-1:0]        : winning index, searched from i_last+1 upward (mod N)
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  localparam int IW = idx_width(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [IW-1:0]        i_last,
  output logic                 o_valid,
  output logic [IW-1:0]        o_idx
);

  // Scan from the farthest candidate (i_last itself) to the nearest
  // (i_last+1); the last hit overwrites earlier ones, so the nearest wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      if (i_req[(int'(i_last) + k) % N_MASTERS]) begin
        o_valid = 1'b1;
        o_idx   = IW'((int'(i_last) + k) % N_MASTERS);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus port between N_MASTERS masters.
// A grant is held for the whole transaction; a watchdog ends transactions
// the slave never completes with an error to the owning master.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   m_bstart/m_ttype/m_tsize/m_addr/m_wdata : per-master request fields
//   m_bgnt                   : one-hot grant
//   m_bdone/m_berror/m_rdata : per-master completion, error, read data
//   s_bstart/s_ttype/s_tsize/s_addr/s_wdata : slave request (muxed from owner)
//   s_rdata/s_bdone/s_berror : slave response
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_MASTERS-1:0]       m_bstart,
  input  ttype_e [N_MASTERS-1:0]     m_ttype,
  input  tsize_e [N_MASTERS-1:0]     m_tsize,
  input  logic [N_MASTERS-1:0][31:0] m_addr,
  input  logic [N_MASTERS-1:0][31:0] m_wdata,
  output logic [N_MASTERS-1:0]       m_bgnt,
  output logic [N_MASTERS-1:0]       m_bdone,
  output logic [N_MASTERS-1:0]       m_berror,
  output logic [N_MASTERS-1:0][31:0] m_rdata,
  output logic                       s_bstart,
  output ttype_e                     s_ttype,
  output tsize_e                     s_tsize,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [31:0]                s_rdata,
  input  logic                       s_bdone,
  input  logic                       s_berror
);

  localparam int IW   = idx_width(N_MASTERS);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic            WD_EN   = (TIMEOUT > 0);

  arb_state_e      r_state, w_state_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [IW-1:0]   r_last,  w_last_nxt;
  logic [WD_W-1:0] r_wd,    w_wd_nxt;

  logic            w_busy;
  logic            w_timeout;
  logic            w_finish;
  logic            w_pick_valid;
  logic [IW-1:0]   w_pick_idx;

  assign w_busy    = (r_state == BUSY);
  // The slave's own completion takes precedence over the watchdog.
  assign w_timeout = WD_EN && w_busy && !s_bdone && (r_wd == WD_LAST);
  assign w_finish  = w_busy && (s_bdone || w_timeout);

  // Same picker serves IDLE arbitration and same-cycle re-arbitration on
  // completion; r_last equals the finishing owner, so it ranks lowest.
  rr_picker #(
    .N_MASTERS (N_MASTERS)
  ) u_picker (
    .i_req   (m_bstart),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= IW'(N_MASTERS - 1);
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_wd_nxt    = r_wd;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = BUSY;
          w_owner_nxt = w_pick_idx;
          w_last_nxt  = w_pick_idx;
          w_wd_nxt    = '0;
        end
      end
      BUSY: begin
        if (w_finish) begin
          w_wd_nxt = '0;
          if (w_pick_valid) begin
            w_owner_nxt = w_pick_idx;
            w_last_nxt  = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (r_wd != '1) begin
          // Saturating count: never wraps back into the expiry window.
          w_wd_nxt = r_wd + WD_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset clears
  // them immediately; the response path is a zero-latency forward.
  always_comb begin
    m_bgnt   = '0;
    m_bdone  = '0;
    m_berror = '0;
    m_rdata  = '0;
    s_bstart = 1'b0;
    s_ttype  = READ;
    s_tsize  = SZ_BYTE;
    s_addr   = '0;
    s_wdata  = '0;
    if (w_busy) begin
      m_bgnt[r_owner]   = 1'b1;
      s_bstart          = 1'b1;
      s_ttype           = m_ttype[r_owner];
      s_tsize           = m_tsize[r_owner];
      s_addr            = m_addr[r_owner];
      s_wdata           = m_wdata[r_owner];
      m_bdone[r_owner]  = s_bdone | w_timeout;
      m_berror[r_owner] = s_berror | w_timeout;
      m_rdata[r_owner]  = w_timeout ? 32'h0 : s_rdata;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       m_bstart;
  ttype_e [1:0]     m_ttype;
  tsize_e [1:0]     m_tsize;
  logic [1:0][31:0] m_addr;
  logic [1:0][31:0] m_wdata;
  logic [1:0]       m_bgnt;
  logic [1:0]       m_bdone;
  logic [1:0]       m_berror;
  logic [1:0][31:0] m_rdata;
  logic             s_bstart;
  ttype_e           s_ttype;
  tsize_e           s_tsize;
  logic [31:0]      s_addr;
  logic [31:0]      s_wdata;
  logic [31:0]      s_rdata;
  logic             s_bdone;
  logic             s_berror;

  bus_arbiter #(
    .N_MASTERS (2),
    .TIMEOUT   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_bstart (m_bstart),
    .m_ttype  (m_ttype),
    .m_tsize  (m_tsize),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_bgnt   (m_bgnt),
    .m_bdone  (m_bdone),
    .m_berror (m_berror),
    .m_rdata  (m_rdata),
    .s_bstart (s_bstart),
    .s_ttype  (s_ttype),
    .s_tsize  (s_tsize),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_bdone  (s_bdone),
    .s_berror (s_berror)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
  } done_t;

  done_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_done(input int idx, input logic err, input logic [31:0] rdata);
    done_t e;
    e.idx   = idx;
    e.err   = err;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completion pulse the DUT presents must match the next
  // expectation queued by the stimulus.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_bdone !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done actual=%b required=00", m_bdone);
      end else begin
        done_t e;
        e = exp_q.pop_front();
        chk("done_vec", 32'(m_bdone), 32'(2'b01 << e.idx));
        chk("done_err", 32'(m_berror), e.err ? 32'(2'b01 << e.idx) : 32'h0);
        chk("done_rdata", m_rdata[e.idx], e.rdata);
        chk("other_rdata", m_rdata[1 - e.idx], 32'h0);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    m_bstart = '0;
    m_ttype  = {READ, READ};
    m_tsize  = {SZ_WORD, SZ_WORD};
    m_addr   = '0;
    m_wdata  = '0;
    s_rdata  = '0;
    s_bdone  = 1'b0;
    s_berror = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    m_bstart = 2'b11;
    m_addr   = {32'hB0, 32'hA0};
    to_neg();
    chk("rst_gnt", 32'(m_bgnt), 32'h0);
    chk("rst_sbstart", 32'(s_bstart), 32'h0);
    chk("rst_saddr", s_addr, 32'h0);
    chk("rst_bdone", 32'(m_bdone), 32'h0);
    to_next();
    rst_n = 1'b1;

    // Both masters hold requests; slave completes 2 cycles after each start
    to_neg();
    chk("idle_gnt", 32'(m_bgnt), 32'h0);
    to_next();
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 3; c++) begin
        s_bdone = (c == 2);
        s_rdata = 32'h1000 + 32'(t);
        if (c == 2) push_done(t % 2, 1'b0, 32'h1000 + 32'(t));
        if (t == 3 && c == 2) m_bstart = 2'b00;
        to_neg();
        chk($sformatf("rr_gnt_t%0d_c%0d", t, c), 32'(m_bgnt), 32'(2'b01 << (t % 2)));
        chk("rr_sbstart", 32'(s_bstart), 32'h1);
        chk("rr_saddr", s_addr, (t % 2 == 0) ? 32'hA0 : 32'hB0);
        to_next();
      end
    end
    s_bdone = 1'b0;
    to_neg();
    chk("rr_end_gnt", 32'(m_bgnt), 32'h0);
    chk("rr_end_sbstart", 32'(s_bstart), 32'h0);
    to_next();

    // Only master 1; slave responds in the first grant cycle
    m_bstart = 2'b10;
    to_next();
    s_bdone  = 1'b1;
    s_rdata  = 32'hDEADBEEF;
    m_bstart = 2'b00;
    push_done(1, 1'b0, 32'hDEADBEEF);
    to_neg();
    chk("m1_gnt", 32'(m_bgnt), 32'h2);
    chk("m1_rdata", m_rdata[1], 32'hDEADBEEF);
    chk("m1_rdata0", m_rdata[0], 32'h0);
    to_next();
    s_bdone = 1'b0;
    s_rdata = '0;

    // Master 0 WRITE held against a mid-transaction request from master 1
    m_bstart   = 2'b01;
    m_ttype[0] = WRITE;
    m_addr     = {32'h200, 32'h100};
    m_wdata    = {32'hAA, 32'h55};
    to_next();
    to_neg();
    chk("wr_gnt", 32'(m_bgnt), 32'h1);
    chk("wr_saddr", s_addr, 32'h100);
    chk("wr_swdata", s_wdata, 32'h55);
    chk("wr_sttype", 32'(s_ttype), 32'(WRITE));
    to_next();
    m_bstart = 2'b11;
    to_neg();
    chk("hold_gnt", 32'(m_bgnt), 32'h1);
    chk("hold_saddr", s_addr, 32'h100);
    to_next();
    s_bdone  = 1'b1;
    s_rdata  = 32'h11;
    m_bstart = 2'b10;
    push_done(0, 1'b0, 32'h11);
    to_neg();
    chk("hold2_swdata", s_wdata, 32'h55);
    to_next();
    s_bdone = 1'b0;
    to_neg();
    chk("sw_gnt", 32'(m_bgnt), 32'h2);
    chk("sw_saddr", s_addr, 32'h200);
    chk("sw_swdata", s_wdata, 32'hAA);
    to_next();
    s_bdone  = 1'b1;
    s_rdata  = 32'h22;
    m_bstart = 2'b00;
    push_done(1, 1'b0, 32'h22);
    to_next();
    s_bdone    = 1'b0;
    m_ttype[0] = READ;

    // Watchdog: slave silent, expiry on the 4th BUSY cycle
    m_bstart = 2'b01;
    s_rdata  = 32'hFFFF;
    to_next();
    for (int c = 0; c < 3; c++) begin
      to_neg();
      chk($sformatf("wd_wait_gnt%0d", c), 32'(m_bgnt), 32'h1);
      to_next();
    end
    m_bstart = 2'b00;
    push_done(0, 1'b1, 32'h0);
    to_next();
    // Late completion with nobody granted
    s_bdone = 1'b1;
    to_neg();
    chk("late_bdone", 32'(m_bdone), 32'h0);
    chk("late_gnt", 32'(m_bgnt), 32'h0);
    to_next();
    s_bdone = 1'b0;

    // Slave completion coincides with expiry: slave wins
    m_bstart = 2'b10;
    to_next();
    repeat (3) to_next();
    s_bdone  = 1'b1;
    s_rdata  = 32'hCAFE0001;
    m_bstart = 2'b00;
    push_done(1, 1'b0, 32'hCAFE0001);
    to_next();
    s_bdone = 1'b0;

    // Slave error reaches only the owner
    m_bstart = 2'b10;
    to_next();
    s_bdone  = 1'b1;
    s_berror = 1'b1;
    s_rdata  = 32'h77;
    m_bstart = 2'b00;
    push_done(1, 1'b1, 32'h77);
    to_neg();
    chk("err_vec", 32'(m_berror), 32'h2);
    to_next();
    s_bdone  = 1'b0;
    s_berror = 1'b0;

    // Reset while BUSY (master 0 owns, so without reset master 1 would be next)
    m_bstart = 2'b01;
    to_next();
    to_neg();
    chk("pre_rst_gnt", 32'(m_bgnt), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(m_bgnt), 32'h0);
    chk("arst_sbstart", 32'(s_bstart), 32'h0);
    chk("arst_bdone", 32'(m_bdone), 32'h0);
    to_next();
    rst_n    = 1'b1;
    m_bstart = 2'b11;
    to_next();
    to_neg();
    chk("post_rst_gnt", 32'(m_bgnt), 32'h1);
    to_next();
    s_bdone  = 1'b1;
    s_rdata  = 32'h5;
    m_bstart = 2'b00;
    push_done(0, 1'b0, 32'h5);
    to_next();
    s_bdone = 1'b0;
    repeat (2) to_next();

    chk("pending_done", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Shares one slave bus port between `N_MASTERS` bus masters, such as the core's `ibus` and `dbus`, so a single memory or interconnect port can serve both.
- Arbitration is round-robin, and a grant is held for the whole transaction.
- A watchdog terminates any transaction the slave never completes, returning an error to the owning master.
- The block sits between `rv_core` and the memory/peripheral slave and speaks the same bus protocol on both sides.

## Interface

Parameters:
- `N_MASTERS`, default 2: number of requesters. Index 0 is `ibus` and index 1 is `dbus` in the core integration.
- `TIMEOUT`, default 256: number of cycles a granted transaction may wait for `s_bdone`. A value of 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-low):
- `clk` — in — 1 — clock.
- `rst_n` — in — 1 — asynchronous active-low reset.
- `m_bstart` — in — [N_MASTERS-1:0] — per-master request.
- `m_ttype` — in — [N_MASTERS-1:0] `ttype_e` — READ or WRITE.
- `m_tsize` — in — [N_MASTERS-1:0] `tsize_e` — transfer size.
- `m_addr` — in — [N_MASTERS-1:0][31:0] — address.
- `m_wdata` — in — [N_MASTERS-1:0][31:0] — write data.
- `m_bgnt` — out — [N_MASTERS-1:0] — one-hot grant.
- `m_bdone` — out — [N_MASTERS-1:0] — transaction complete (one-cycle pulse).
- `m_berror` — out — [N_MASTERS-1:0] — error, valid with `m_bdone`.
- `m_rdata` — out — [N_MASTERS-1:0][31:0] — read data, valid with `m_bdone`.
- `s_bstart` — out — 1 — slave request.
- `s_ttype` — out — `ttype_e` — muxed from the owner.
- `s_tsize` — out — `tsize_e` — muxed from the owner.
- `s_addr` — out — 32 — muxed from the owner.
- `s_wdata` — out — 32 — muxed from the owner.
- `s_rdata` — in — 32 — slave read data.
- `s_bdone` — in — 1 — slave completion pulse.
- `s_berror` — in — 1 — slave error, valid with `s_bdone`.

## Operation

States:
- IDLE: no owner.
- BUSY: `owner` register holds the granted index.

IDLE:
- If any `m_bstart` is high, pick a winner by round-robin starting at `last+1` (mod N). Register it as `owner`, set `last` to the winner, and go to BUSY.
- If no request is present, stay in IDLE.

BUSY outputs:
- `m_bgnt[owner]=1`.
- `s_bstart=1`.
- `s_*` request fields are driven combinationally from the owner's `m_*` fields.

Completion in BUSY:
- Forward combinationally in the same cycle: `m_bdone[owner]=s_bdone`, `m_berror[owner]=s_berror`, `m_rdata[owner]=s_rdata`.
- All non-owner `m_bdone`, `m_berror` and `m_rdata` outputs are 0.
- On `s_bdone`, re-arbitrate in the same cycle. The just-finished owner gets the lowest priority; the requester it would pick is `last+1` onward.
- If any `m_bstart` is high, load the new owner and stay in BUSY with no idle cycle. Otherwise go to IDLE.

Transaction boundaries:
- A new slave transaction begins on any cycle with `s_bstart=1` where the previous cycle had `s_bstart=0` or `s_bdone=1`.
- A master that drops `m_bstart` while granted does not cancel its transaction. The grant is held until `s_bdone` or timeout.

Watchdog:
- Counter `wd` clears on entry to BUSY and on every owner change, and increments each BUSY cycle without `s_bdone`.
- When `wd==TIMEOUT-1` and `s_bdone=0`, the arbiter itself pulses `m_bdone[owner]=1` and `m_berror[owner]=1`, with `m_rdata[owner]=0`.
- It then re-arbitrates exactly as on a normal completion.
- A late `s_bdone` that arrives after a timeout with no owner granted is ignored.
- `wd` saturates, so it never wraps. Its width is `$clog2(TIMEOUT+1)`.

## Timing

Reset values:
- state=IDLE.
- `last=N_MASTERS-1`, so master 0 wins first.
- `owner=0`, `wd=0`.
- All `m_bgnt`, `m_bdone`, `m_berror`, `m_rdata` and `s_bstart` are 0; `s_*` request fields are 0.

Latency and throughput:
- A request in IDLE at cycle t gets `m_bgnt` and `s_bstart` at t+1.
- The response path is 0 cycles: `s_bdone` appears on `m_bdone` in the same cycle.
- Back-to-back transactions to different or the same masters have no bubble.

Boundary conditions:
- Simultaneous requests in IDLE: round-robin decides.
- Simultaneous `s_bdone` and watchdog expiry: `s_bdone` wins, with the slave's data and error.
- Reset mid-transaction aborts it asynchronously. No `m_bdone` is delivered, and outputs go to their reset values immediately.

## Structure

- `ttype_e` and `tsize_e` stay in `bus_if.svh`.
- Add `arb_state_e` (IDLE, BUSY) to the same shared header.
- One sub-module, `rr_picker`: purely combinational.
  - Inputs: request vector and `last`.
  - Outputs: `valid` and the winner index.
  - Used in both IDLE and BUSY re-arbitration.

## Test plan

- Reset, then `m_bstart=2'b11` held, with the slave returning `s_bdone` 2 cycles after each start → grants go 0,1,0,1; `s_bstart` is continuously 1; no idle cycle between grants.
- Only master 1 requests; the slave returns `s_rdata=32'hDEADBEEF` and `s_bdone` in the first grant cycle → `m_bdone[1]=1` and `m_rdata[1]=32'hDEADBEEF` that cycle; `m_rdata[0]=0`.
- Master 0 WRITE with `addr=32'h100` and `wdata=32'h55`; master 1 raises a request mid-transaction → `s_addr` and `s_wdata` stay at master 0's values until `s_bdone`; master 1 is granted on the next cycle's edge.
- `TIMEOUT=4`, slave never responds → on the 4th BUSY cycle `m_bdone[owner]=1` and `m_berror[owner]=1`; a late `s_bdone` in IDLE produces no `m_bdone`.
- Slave returns `s_berror=1` with `s_bdone` → the error reaches only the owner's `m_berror`.
- `rst_n` asserted while BUSY → `m_bgnt` and `s_bstart` go to 0 before the next clock edge; after release, master 0 wins first.
